fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL: rd_en  input  1  drain enable; 0 = issue no new pops.
REQ-004 SHALL: fifo_empty  input  1  empty flag from the 8-deep byte FIFO.
REQ-005 SHALL: fifo_data  input  8  FIFO read data, registered one cycle after an accepted pop.
REQ-006 SHALL: fifo_pop  output  1  pop request to the FIFO.
REQ-007 SHALL: m_data  output  8  downstream stream data.
REQ-008 SHALL: m_valid  output  1  downstream data valid.
REQ-009 SHALL: m_ready  input  1  downstream ready; transfer when m_valid && m_ready.
REQ-010 SHALL: rd_count  output  16  bytes delivered downstream; present only with FIFO_RD_STATS_EN.

Function
REQ-011 SHALL: hold a 3-entry skid buffer: occupancy occ (0..3), head/tail pointers (0..2, wrap 2->0), and a 1-bit inflight flag.
REQ-012 SHALL: drive fifo_pop = rd_en && !fifo_empty && (occ + inflight < 3); no combinational path from m_ready to fifo_pop.
REQ-013 SHALL: set inflight to the registered value of fifo_pop each cycle.
REQ-014 SHALL: when inflight=1, write fifo_data into buffer[tail] at that edge and advance tail.
REQ-015 SHALL: drive m_valid = (occ != 0) and m_data = buffer[head], both combinational from registers; on transfer, advance head.
REQ-016 SHALL: occ next = occ + inflight - transfer; a simultaneous capture and transfer leaves occ unchanged.
REQ-017 SHALL: keep m_data stable while m_valid=1 and m_ready=0.
REQ-018 SHALL: have a latency of 2 cycles: pop in cycle N -> capture at end of N+1 -> m_valid=1 in cycle N+2.
REQ-019 SHALL: sustain one byte per cycle with m_ready held high and the FIFO non-empty, after the initial 2-cycle latency.
REQ-020 SHALL: deliver bytes in exact FIFO order with no loss or duplication across pointer wrap.
REQ-021 SHALL: when rd_en is deasserted, still capture an in-flight byte and keep presenting buffered bytes.
REQ-022 SHALL: when occ=3, assert no pop, so capture never overflows the buffer.

Reset
REQ-023 SHALL: on rst, clear occ, head, tail, and inflight immediately; fifo_pop=0, m_valid=0, m_data=buffer[0] (don't-care).
REQ-024 SHALL: on rst mid-operation, discard buffered and in-flight bytes, since the FIFO shares rst and is emptied too.
REQ-025 SHALL: not reset buffer storage.
REQ-026 SHALL: on rst, set rd_count=0 (with macro).

Configuration
REQ-027 SHALL: when FIFO_RD_STATS_EN is defined, provide port rd_count, which increments by 1 per transfer and wraps from 65535 to 0.
REQ-028 SHALL: when FIFO_RD_STATS_EN is undefined, have no rd_count port or counter logic; all other behaviour is identical.

Verification
REQ-029 SHALL: push 0x11 into empty FIFO, rd_en=1, m_ready=1 -> fifo_pop for 1 cycle; 2 cycles later m_valid=1, m_data=0x11 for 1 cycle.
REQ-030 SHALL: FIFO holds 0x01..0x08, m_ready=1 -> m_data 0x01..0x08 on 8 consecutive cycles, then m_valid=0.
REQ-031 SHALL: FIFO holds 0x01..0x08, m_ready=0 -> exactly 3 pops, occ=3, m_data=0x01 stable; then m_ready=1 -> 0x01..0x08 in order, with pointer wrap exercised.
REQ-032 SHALL: random m_ready (50%) over 200 bytes -> in-order output, no loss or duplicates; with macro, rd_count=200.
REQ-033 SHALL: assert rst while occ=2 and inflight=1 -> m_valid=0 and fifo_pop=0 in the same cycle; after release, a new byte 0xA5 is delivered correctly.
REQ-034 SHALL: deassert rd_en in the cycle after a pop -> in-flight byte still delivered, no further pops until rd_en=1.

Source files
------------

// File: rtl/fifo_reader.sv
// Drains an 8-deep byte FIFO into a valid/ready stream through a 3-entry skid buffer.
// Define FIFO_RD_STATS_EN to add the rd_count delivered-byte counter port.
module fifo_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_pop,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0] rd_count
`endif
);

    localparam int DEPTH = 3;

    logic [1:0] occ_q, occ_d;
    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic       inflight_q;
    logic [7:0] buf_q [DEPTH];
    logic [2:0] pend;
    logic       xfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Bytes already committed (buffered + in flight) must leave room for a new pop,
    // so the pop decision never looks at m_ready.
    assign pend     = {1'b0, occ_q} + {2'b00, inflight_q};
    assign fifo_pop = !rst && rd_en && !fifo_empty && (pend < 3'd3);

    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[head_q];
    assign xfer     = m_valid && m_ready;

    always_comb begin
        head_d = xfer       ? ptr_inc(head_q) : head_q;
        tail_d = inflight_q ? ptr_inc(tail_q) : tail_q;
        occ_d  = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q      <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            inflight_q <= fifo_pop;
        end
    end

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (inflight_q)
            buf_q[tail_q] <= fifo_data;
    end

`ifdef FIFO_RD_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d    = xfer ? cnt_q + 16'd1 : cnt_q;
    assign rd_count = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else     cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural 8-deep FIFO (registered read data).
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [1024];
    int wptr = 0;
    int rptr = 0;

    fifo_reader dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_pop   (fifo_pop),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wptr == rptr);

    // FIFO model: shares rst (flushes), read data registered after an accepted pop
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr <= wptr;
        end else if (fifo_pop && (wptr != rptr)) begin
            fifo_data <= mem[rptr];
            rptr      <= rptr + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wptr] = b;
        wptr = wptr + 1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; m_ready = 1'b0;
        nxt(); nxt();
        push(8'h77); rd_en = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (rd_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rd_count); end
`endif
        nxt();
        rst = 1'b0; rd_en = 1'b0;
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_rel_valid got=%b exp=0", m_valid); end
        checks++; if (fifo_empty !== 1'b1 || fifo_pop !== 1'b0) begin errors++; $display("FAIL reset_flush empty=%b pop=%b exp 1/0", fifo_empty, fifo_pop); end
    endtask

    task automatic test_single();
        nxt(); push(8'h11); rd_en = 1'b1; m_ready = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL single_pop got=%b exp=1", fifo_pop); end
        nxt(); #1;
        checks++; if (fifo_pop !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL single_n1 pop=%b valid=%b exp 0/0", fifo_pop, m_valid); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin errors++; $display("FAIL single_data valid=%b data=%h exp 1/11", m_valid, m_data); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_after valid=%b exp=0", m_valid); end
    endtask

    task automatic test_stream8();
        nxt(); m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(8'(i));
        rd_en = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b1 || m_valid !== 1'b0) begin errors++; $display("FAIL stream_start pop=%b valid=%b exp 1/0", fifo_pop, m_valid); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_lat valid=%b exp=0", m_valid); end
        for (int i = 1; i <= 8; i++) begin
            nxt(); #1;
            checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin errors++; $display("FAIL stream_byte%0d valid=%b data=%h exp 1/%h", i, m_valid, m_data, 8'(i)); end
        end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stream_end valid=%b exp=0", m_valid); end
    endtask

    task automatic test_backpressure();
        int pops;
        pops = 0;
        nxt(); m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1; if (fifo_pop === 1'b1) pops++;
            nxt();
        end
        #1;
        checks++; if (pops != 3) begin errors++; $display("FAIL bp_pops got=%0d exp=3", pops); end
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h01) begin errors++; $display("FAIL bp_hold valid=%b data=%h exp 1/01", m_valid, m_data); end
        nxt(); #1;
        checks++; if (m_data !== 8'h01 || fifo_pop !== 1'b0) begin errors++; $display("FAIL bp_stable data=%h pop=%b exp 01/0", m_data, fifo_pop); end
        nxt(); m_ready = 1'b1; #1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin errors++; $display("FAIL bp_byte%0d valid=%b data=%h exp 1/%h", i, m_valid, m_data, 8'(i)); end
            nxt(); #1;
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_end valid=%b exp=0", m_valid); end
    endtask

    task automatic test_rd_en_gap();
        nxt(); m_ready = 1'b1;
        push(8'h31); push(8'h32); rd_en = 1'b1;
        #1;
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL gap_pop1 got=%b exp=1", fifo_pop); end
        nxt(); rd_en = 1'b0; #1;
        checks++; if (fifo_pop !== 1'b0) begin errors++; $display("FAIL gap_nopop got=%b exp=0", fifo_pop); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h31) begin errors++; $display("FAIL gap_inflight valid=%b data=%h exp 1/31", m_valid, m_data); end
        for (int k = 0; k < 3; k++) begin
            nxt(); #1;
            checks++; if (fifo_pop !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL gap_idle%0d pop=%b valid=%b exp 0/0", k, fifo_pop, m_valid); end
        end
        nxt(); rd_en = 1'b1; #1;
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL gap_resume got=%b exp=1", fifo_pop); end
        nxt(); nxt(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h32) begin errors++; $display("FAIL gap_second valid=%b data=%h exp 1/32", m_valid, m_data); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL gap_end valid=%b exp=0", m_valid); end
    endtask

    task automatic test_mid_reset();
        nxt(); m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
        rd_en = 1'b1;
        nxt(); nxt(); nxt(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'h41) begin errors++; $display("FAIL mr_pre valid=%b data=%h exp 1/41", m_valid, m_data); end
        rst = 1'b1; #1;
        checks++; if (m_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL mr_now valid=%b pop=%b exp 0/0", m_valid, fifo_pop); end
        nxt(); rst = 1'b0; m_ready = 1'b1; #1;
        checks++; if (m_valid !== 1'b0 || fifo_pop !== 1'b0) begin errors++; $display("FAIL mr_rel valid=%b pop=%b exp 0/0", m_valid, fifo_pop); end
        nxt(); push(8'hA5); #1;
        checks++; if (fifo_pop !== 1'b1) begin errors++; $display("FAIL mr_pop got=%b exp=1", fifo_pop); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_lat valid=%b exp=0", m_valid); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 8'hA5) begin errors++; $display("FAIL mr_data valid=%b data=%h exp 1/a5", m_valid, m_data); end
        nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mr_end valid=%b exp=0", m_valid); end
    endtask

    task automatic test_random();
        int pushed, got, bad;
        pushed = 0; got = 0; bad = 0;
        nxt(); rst = 1'b1; rd_en = 1'b0; m_ready = 1'b0;
        nxt(); rst = 1'b0; rd_en = 1'b1;
        for (int c = 0; c < 2000 && got < 200; c++) begin
            if (pushed < 200 && (wptr - rptr) < 8) begin
                push(8'((pushed * 37 + 5) & 255));
                pushed++;
            end
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                checks++;
                if (m_data !== 8'((got * 37 + 5) & 255)) begin
                    errors++; bad++;
                    if (bad <= 5) $display("FAIL rand_byte%0d got=%h exp=%h", got, m_data, 8'((got * 37 + 5) & 255));
                end
                got++;
            end
            nxt();
        end
        checks++; if (got != 200) begin errors++; $display("FAIL rand_count got=%0d exp=200", got); end
        m_ready = 1'b1;
        nxt(); nxt(); nxt(); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rand_extra valid=%b exp=0", m_valid); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (rd_count !== 16'd200) begin errors++; $display("FAIL rand_rd_count got=%0d exp=200", rd_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream8();
        test_backpressure();
        test_rd_en_gap();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
